// File: rtl/mic_array_rx.sv
// mic_array_rx: multi-pair I2S microphone receiver.
// Aligns N_PAIRS stereo lines and delivers whole frames over valid/ready.
module mic_array_rx #(
   parameter int N_PAIRS = 3,
   parameter int DATA_W  = 16,
   parameter int SLOT_W  = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          bclk,
   input  logic                          lrc,
   input  logic [N_PAIRS-1:0]            sd,
   input  logic [2*N_PAIRS-1:0]          ch_mask,
   output logic [2*N_PAIRS*DATA_W-1:0]   frame_data,
   output logic                          frame_valid,
   input  logic                          frame_ready,
   output logic [7:0]                    overrun_cnt,
   output logic                          frame_err,
   output logic                          locked
);

   localparam int NCH = 2 * N_PAIRS;
   localparam int WW  = N_PAIRS * DATA_W;
   localparam int BW  = $clog2(DATA_W);
   localparam int CW  = $clog2(SLOT_W + 1);

   typedef enum logic [1:0] {HUNT, SKIP, SHIFT, DONE} state_t;

   state_t state, state_n;

   logic [2:0]          bclk_q;
   logic [1:0]          lrc_q;
   logic [N_PAIRS-1:0]  sd_q1, sd_q2;
   logic                rise, lrc_s, chg, long_slot, xfer;
   logic                last_lrc, side, side_n;
   logic [BW-1:0]       bit_cnt;
   logic [CW-1:0]       rise_cnt;
   logic [WW-1:0]       sh_l, sh_r, l_hold, r_hold;
   logic                do_shift, latch_l, fault, lock_go, last_bit;
   logic                last_q, commit;
   logic [NCH*DATA_W-1:0] masked;

   assign rise      = bclk_q[1] & ~bclk_q[2];
   assign lrc_s     = lrc_q[1];
   assign chg       = rise & (lrc_s != last_lrc);
   assign long_slot = rise & ~chg & (rise_cnt == CW'(SLOT_W));
   assign xfer      = frame_valid & frame_ready;

   // Bring the I2S pins into the clk domain; bclk gets a third stage for edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         bclk_q   <= '0;
         lrc_q    <= '0;
         sd_q1    <= '0;
         sd_q2    <= '0;
         last_lrc <= 1'b0;
      end else begin
         bclk_q <= {bclk_q[1:0], bclk};
         lrc_q  <= {lrc_q[0], lrc};
         sd_q1  <= sd;
         sd_q2  <= sd_q1;
         if (rise) last_lrc <= lrc_s;
      end
   end

   // Frame alignment state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
         side  <= 1'b0;
      end else begin
         state <= state_n;
         side  <= side_n;
      end
   end

   // Next-state logic; any slot that is too short or too long drops lock.
   always_comb begin
      state_n  = state;
      side_n   = side;
      do_shift = 1'b0;
      latch_l  = 1'b0;
      fault    = 1'b0;
      lock_go  = 1'b0;
      last_bit = 1'b0;
      unique case (state)
         HUNT: begin
            if (chg && !lrc_s) begin
               state_n = SKIP;
               side_n  = 1'b0;
               lock_go = 1'b1;
            end
         end
         SKIP: begin
            state_n = SHIFT;
         end
         SHIFT: begin
            if (chg || long_slot) begin
               fault   = 1'b1;
               state_n = HUNT;
            end else if (rise) begin
               do_shift = 1'b1;
               if (bit_cnt == BW'(DATA_W - 1)) begin
                  state_n  = DONE;
                  last_bit = side;
               end
            end
         end
         DONE: begin
            if (long_slot) begin
               fault   = 1'b1;
               state_n = HUNT;
            end else if (chg) begin
               state_n = SKIP;
               side_n  = lrc_s;
               latch_l = lrc_s;
            end
         end
      endcase
   end

   // Bit and slot counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt  <= '0;
         rise_cnt <= '0;
      end else begin
         if (state == SKIP)
            bit_cnt <= '0;
         else if (do_shift)
            bit_cnt <= bit_cnt + 1'b1;
         if (lock_go || (state == DONE && chg))
            rise_cnt <= CW'(1);
         else if (rise && state != HUNT && !fault)
            rise_cnt <= rise_cnt + 1'b1;
      end
   end

   // Per-pair shift registers, left holding words and the commit pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_l   <= '0;
         sh_r   <= '0;
         l_hold <= '0;
         r_hold <= '0;
         last_q <= 1'b0;
         commit <= 1'b0;
      end else begin
         if (do_shift) begin
            for (int p = 0; p < N_PAIRS; p++) begin
               if (side)
                  sh_r[p*DATA_W +: DATA_W] <=
                     {sh_r[p*DATA_W +: DATA_W-1], sd_q2[p]};
               else
                  sh_l[p*DATA_W +: DATA_W] <=
                     {sh_l[p*DATA_W +: DATA_W-1], sd_q2[p]};
            end
         end
         if (fault)
            l_hold <= '0;
         else if (latch_l)
            l_hold <= sh_l;
         last_q <= last_bit;
         if (last_q) r_hold <= sh_r;
         commit <= last_q;
      end
   end

   // Interleave channels and zero the disabled ones.
   always_comb begin
      masked = '0;
      for (int p = 0; p < N_PAIRS; p++) begin
         if (ch_mask[2*p])
            masked[2*p*DATA_W +: DATA_W] = l_hold[p*DATA_W +: DATA_W];
         if (ch_mask[2*p+1])
            masked[(2*p+1)*DATA_W +: DATA_W] = r_hold[p*DATA_W +: DATA_W];
      end
   end

   // Output frame register with valid/ready handshake and overrun count.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_data  <= '0;
         frame_valid <= 1'b0;
         overrun_cnt <= '0;
      end else if (commit) begin
         frame_data  <= masked;
         frame_valid <= 1'b1;
         if (frame_valid && !xfer && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
      end else if (xfer) begin
         frame_valid <= 1'b0;
      end
   end

   // Lock indication and sticky framing error.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
         locked    <= 1'b0;
      end else if (fault) begin
         frame_err <= 1'b1;
         locked    <= 1'b0;
      end else if (lock_go) begin
         locked <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mic_array_rx.sv
// tb_mic_array_rx: randomized bench for mic_array_rx.
// A half-frame level reference model predicts frames, lock and errors.
module tb_mic_array_rx;

   localparam int NP  = 2;
   localparam int DW  = 16;
   localparam int SW  = 32;
   localparam int NCH = 2 * NP;
   localparam int FW  = NCH * DW;
   localparam int WW  = NP * DW;

   logic            clk = 1'b0;
   logic            rst, bclk, lrc;
   logic [NP-1:0]   sd;
   logic [NCH-1:0]  ch_mask;
   logic [FW-1:0]   frame_data;
   logic            frame_valid, frame_ready;
   logic [7:0]      overrun_cnt;
   logic            frame_err, locked;

   mic_array_rx #(.N_PAIRS(NP), .DATA_W(DW), .SLOT_W(SW)) dut (
      .clk(clk), .rst(rst), .bclk(bclk), .lrc(lrc), .sd(sd),
      .ch_mask(ch_mask), .frame_data(frame_data),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .overrun_cnt(overrun_cnt), .frame_err(frame_err), .locked(locked)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int bad_cnt = 0;

   task automatic chk(input string tag, input logic [FW-1:0] got,
                      input logic [FW-1:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   logic [FW-1:0] m_data, last_acc;
   logic          m_valid, m_err, m_locked, m_prev;
   int            m_ovr, m_cnt, mcyc, rmode;
   logic [WW-1:0] m_left;
   int            cq_t[$];
   logic [FW-1:0] cq_f[$];

   function automatic logic [FW-1:0] mkframe(input logic [WW-1:0] l,
                                             input logic [WW-1:0] r);
      logic [FW-1:0] f;
      for (int p = 0; p < NP; p++) begin
         f[2*p*DW +: DW]     = l[p*DW +: DW];
         f[(2*p+1)*DW +: DW] = r[p*DW +: DW];
      end
      return f;
   endfunction

   // One clk period: check outputs, drive pins, advance the handshake model.
   task automatic step(input logic b, input logic l, input logic [NP-1:0] s,
                       input logic r_in, input int sel);
      logic          xfer;
      logic [FW-1:0] f;
      @(negedge clk);
      chk("valid", FW'(frame_valid), FW'(m_valid));
      chk("overrun", FW'(overrun_cnt), FW'(m_ovr));
      if (m_valid || sel == 2) chk("data", frame_data, m_data);
      if (sel != 0) begin
         chk("locked", FW'(locked), FW'(m_locked));
         chk("frame_err", FW'(frame_err), FW'(m_err));
      end
      bclk = b;
      lrc  = l;
      sd   = s;
      rst  = r_in;
      case (rmode)
         0:       frame_ready = 1'b0;
         1:       frame_ready = 1'b1;
         default: frame_ready = 1'($urandom_range(0, 1));
      endcase
      if (frame_valid && frame_ready) last_acc = frame_data;
      if (r_in) begin
         m_data = '0; m_valid = 1'b0; m_ovr = 0;
         m_err = 1'b0; m_locked = 1'b0; m_prev = 1'b0; m_cnt = 0;
         cq_t.delete();
         cq_f.delete();
      end else begin
         xfer = m_valid && frame_ready;
         if (cq_t.size() > 0 && cq_t[0] == mcyc) begin
            f = cq_f.pop_front();
            void'(cq_t.pop_front());
            for (int c = 0; c < NCH; c++)
               if (!ch_mask[c]) f[c*DW +: DW] = '0;
            if (m_valid && !xfer && m_ovr < 255) m_ovr++;
            m_data  = f;
            m_valid = 1'b1;
         end else if (xfer) begin
            m_valid = 1'b0;
         end
      end
      mcyc++;
   endtask

   // Effect of one bclk rise, counted per half-frame.
   task automatic rise_model(input logic side, input logic [WW-1:0] w);
      if (side != m_prev) begin
         if (m_locked) begin
            if (m_cnt < DW + 1) begin
               m_err = 1'b1;
               m_locked = 1'b0;
            end else begin
               m_cnt = 1;
            end
         end else if (m_prev && !side) begin
            m_locked = 1'b1;
            m_cnt = 1;
         end
         m_prev = side;
      end else if (m_locked) begin
         m_cnt++;
         if (m_cnt > SW) begin
            m_err = 1'b1;
            m_locked = 1'b0;
         end else if (side && m_cnt == DW + 1) begin
            cq_t.push_back(mcyc + 4);
            cq_f.push_back(mkframe(m_left, w));
         end
      end
   endtask

   // One half-frame of n bclk periods (8 clk each), words MSB first.
   task automatic send_half(input logic side, input int n,
                            input logic [WW-1:0] w, input int rst_at);
      logic [NP-1:0] s;
      if (!side) m_left = w;
      for (int r = 1; r <= n; r++) begin
         for (int p = 0; p < NP; p++)
            if (r >= 2 && r <= DW + 1)
               s[p] = w[p*DW + DW + 1 - r];
            else
               s[p] = 1'($urandom_range(0, 1));
         step(1'b0, side, s, 1'b0, 0);
         step(1'b0, side, s, r == rst_at, 0);
         step(1'b0, side, s, 1'b0, (r == rst_at) ? 2 : 0);
         step(1'b0, side, s, 1'b0, 0);
         rise_model(side, w);
         step(1'b1, side, s, 1'b0, 0);
         step(1'b1, side, s, 1'b0, 0);
         step(1'b1, side, s, 1'b0, 0);
         step(1'b1, side, s, 1'b0, 1);
      end
   endtask

   function automatic int pick_len();
      int k;
      k = int'($urandom_range(0, 9));
      if (k == 0) return 10;
      if (k == 1) return SW + 2;
      return int'($urandom_range(DW + 1, SW));
   endfunction

   initial begin
      logic [WW-1:0] wl, wr;
      int nl, nr;
      rst = 1'b1; bclk = 1'b0; lrc = 1'b1; sd = '0;
      ch_mask = '1; frame_ready = 1'b1;
      rmode = 1; mcyc = 0; last_acc = '0;
      m_data = '0; m_valid = 1'b0; m_ovr = 0; m_err = 1'b0;
      m_locked = 1'b0; m_prev = 1'b0; m_cnt = 0; m_left = '0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b1, 0);
      step(1'b0, 1'b1, '0, 1'b0, 2);

      send_half(1'b1, 12, WW'($urandom), 0);
      wl = {16'h8001, 16'h1234};
      wr = {16'h7FFF, 16'hABCD};
      send_half(1'b0, SW, wl, 0);
      send_half(1'b1, SW, wr, 0);
      chk("frame_full", last_acc, 64'h7FFF_8001_ABCD_1234);
      chk("locked_dir", FW'(locked), FW'(1));

      ch_mask = 4'b1010;
      send_half(1'b0, SW, wl, 0);
      send_half(1'b1, SW, wr, 0);
      chk("frame_mask", last_acc, 64'h7FFF_0000_ABCD_0000);

      ch_mask = '1;
      rmode = 0;
      for (int i = 0; i < 3; i++) begin
         send_half(1'b0, SW, WW'($urandom), 0);
         send_half(1'b1, SW, WW'($urandom), 0);
      end
      chk("ovr_hold", FW'(overrun_cnt), FW'(2));
      rmode = 1;

      send_half(1'b0, SW, WW'($urandom), 0);
      send_half(1'b1, 10, WW'($urandom), 0);
      send_half(1'b0, SW, WW'($urandom), 0);
      chk("err_set", FW'(frame_err), FW'(1));
      chk("unlock", FW'(locked), FW'(0));
      send_half(1'b1, SW, WW'($urandom), 0);
      wl = {16'h0F0F, 16'h8000};
      wr = {16'h7FFE, 16'h00FF};
      send_half(1'b0, SW, wl, 0);
      send_half(1'b1, SW, wr, 0);
      chk("after_err", last_acc, 64'h7FFE_0F0F_00FF_8000);

      send_half(1'b0, SW, WW'($urandom), 5);
      send_half(1'b1, SW, WW'($urandom), 0);
      wl = {16'h5A5A, 16'hC3C3};
      wr = {16'hFFFF, 16'h0001};
      send_half(1'b0, SW, wl, 0);
      send_half(1'b1, SW, wr, 0);
      chk("after_rst", last_acc, 64'hFFFF_5A5A_0001_C3C3);
      chk("ovr_rst", FW'(overrun_cnt), FW'(0));

      rmode = 2;
      for (int i = 0; i < 24; i++) begin
         ch_mask = NCH'($urandom_range(0, 15));
         nl = pick_len();
         nr = pick_len();
         send_half(1'b0, nl, WW'($urandom), 0);
         send_half(1'b1, nr, WW'($urandom), 0);
      end

      rmode = 1;
      send_half(1'b0, 4, WW'($urandom), 0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/mic_array_rx.md
Name: mic_array_rx

Overview:
- Parametrised successor to the per-pair stereo mic deserialiser: one block receives N_PAIRS I2S stereo mic data lines that share a single bclk/lrc pair.
- Delivers all 2*N_PAIRS samples of one audio frame together, word-aligned, through a valid/ready handshake.
- Adds configurable sample/slot width, frame-integrity checking, overrun counting and per-channel masking.
- Sits between the mic pins and the ANC/BOOT datapaths, replacing the multiple receiver instances.

Parameters:
- N_PAIRS, 3, number of stereo data lines (channels = 2*N_PAIRS).
- DATA_W, 16, captured bits per sample, MSB first (range 8..SLOT_W-1).
- SLOT_W, 32, bclk cycles per half-frame (lrc level).

Ports:
- clk  in  1  system clock; bclk/lrc/sd are oversampled in this domain.
- rst  in  1  synchronous, active-high reset.
- bclk  in  1  I2S bit clock (asynchronous to clk).
- lrc  in  1  I2S word select: 0 = left, 1 = right.
- sd  in  N_PAIRS  serial data; bit p = pair p.
- ch_mask  in  2*N_PAIRS  1 = channel enabled; disabled channels output 0. Bit 2p = left of pair p, bit 2p+1 = right.
- frame_data  out  2*N_PAIRS*DATA_W  channel c occupies [c*DATA_W +: DATA_W], signed two's complement.
- frame_valid  out  1  frame available.
- frame_ready  in  1  consumer accepts frame.
- overrun_cnt  out  8  saturating count of frames overwritten before acceptance.
- frame_err  out  1  sticky short-half-frame error; cleared only by rst.
- locked  out  1  aligned to frame boundary.

Behaviour:
- Input synchronisation: bclk, lrc and sd each pass through 2 flops, plus a 3rd flop for edge detection. A bclk rising edge (rise) is recognised when stage2=1 and stage3=0. All sampling uses stage2 values on rise cycles.
- I2S format: the first rise after an lrc level change is the delay bit and is ignored. The next DATA_W rises are MSB..LSB. Remaining rises in the slot are ignored.
- Reset values: frame_data=0, frame_valid=0, overrun_cnt=0, frame_err=0, locked=0, state=HUNT, bit counter=0.
- FSM states:
  - HUNT: wait for an lrc 1->0 change seen on a rise -> SKIP, locked=1.
  - SKIP: that rise is the delay bit; clear bit_cnt -> SHIFT.
  - SHIFT: on each rise shift stage2 sd[p] into the pair-p shift register for the current side; bit_cnt++. At bit_cnt==DATA_W-1 (last bit) -> DONE.
  - DONE: ignore rises until lrc changes. Left->right change: latch left words to holding regs, -> SKIP. Right->left change: -> SKIP (new frame).
- Half-frame length check: count all rises per half-frame. If lrc changes while in SKIP/SHIFT (fewer than DATA_W+1 rises):
  - discard the partial sample and any held left words;
  - set frame_err;
  - locked=0, -> HUNT.
  - That change is not reused for alignment; HUNT waits for the next 1->0.
- More than SLOT_W rises without an lrc change: treated identically (frame_err, HUNT).
- Commit: the cycle after the last right bit is shifted:
  - frame_data <= left/right words of all pairs, with masked channels forced to 0;
  - frame_valid <= 1.
  - Latency: frame_valid rises 4 clk cycles after the first clk edge that samples raw bclk high for the last right bit.
- Handshake: a transfer occurs on any clk edge with frame_valid && frame_ready; frame_valid then drops next cycle unless a commit occurs in the same cycle. frame_data is stable while frame_valid=1 and not transferred.
- Commit while frame_valid=1 and no transfer that cycle: frame_data is overwritten with the new frame, frame_valid stays 1, overrun_cnt++ (saturates at 255).
- Commit coinciding with a transfer: the new frame loads, frame_valid stays 1, no overrun.
- Mid-frame rst: all state returns to reset values next edge; re-lock waits for the next lrc 1->0.
- ch_mask is sampled at commit only; changes mid-frame do not corrupt the held frame.

Test Plan:
- N_PAIRS=2, DATA_W=16, SLOT_W=32, bclk=clk/8. Send frame L0=0x1234, R0=0xABCD, L1=0x8001, R1=0x7FFF, frame_ready=1, ch_mask=4'hF -> frame_data=0x7FFF_8001_ABCD_1234; frame_valid high exactly 1 cycle, 4 clk after the last bclk rise; locked=1.
- Same stimulus with ch_mask=4'b1010 -> frame_data=0x7FFF_0000_ABCD_0000.
- frame_ready=0 across 3 frames, then 1 -> frame_valid held high; frame_data = the third frame; overrun_cnt=2; after acceptance frame_valid=0.
- Start stimulus mid-right-slot -> no frame_valid until the first full left+right frame after an lrc 1->0; frame_err stays 0.
- Shorten one right half-frame to 10 bclk -> frame_err=1, locked=0, that frame is not delivered; the next complete frame is delivered correctly.
- Assert rst for 1 cycle during the left slot -> all outputs 0 next cycle; the following frame (after the next lrc 1->0) is received correctly; overrun_cnt=0.
